// File: rtl/bg_sar_ctrl.sv
// -----------------------------------------------------------------------------
// bg_sar_ctrl
//
// Digital sequencer for the switched-capacitor bandgap core. It powers up the
// core and runs the diode/capacitor phase sequence for each comparison:
//   CHARGE_A (unit diode on cap 1) -> GAP_A -> CHARGE_B (N diodes on cap 2)
//   -> GAP_B -> SHARE (both caps shared) -> DECIDE.
// The comparator result from each sequence drives an MSB-first successive
// approximation search on the fine IDAC code. When the last bit is resolved,
// the code is published and done pulses for one cycle.
//
// Optional feature (macro BG_SAR_CTRL_CHOP_EN):
//   Each bit is evaluated twice. Pass 1 uses cmp_swap=0. Pass 2 uses
//   cmp_swap=1 and inverts the synchronized comparator output. A bit is
//   cleared only when both passes ask for it to be cleared.
//   Without the macro, cmp_swap is tied low and each bit takes one pass.
//
// Ports:
//   clk             system clock
//   reset           synchronous active-high reset
//   start           one-cycle conversion request, accepted only in IDLE
//   coarse_in       coarse IDAC code, latched on accepted start
//   diode_n_sel     diode pattern for the N-diode phase, latched on start
//   cmpo            comparator output (asynchronous, 2-flop synchronized)
//   pwrup           core power-up
//   idacFine        SAR trial code
//   idacCoarse      latched coarse IDAC code
//   idacOutSelect_n IDAC output enables, active-low
//   diodeSelect     diode bank select
//   resStableSelect stable-resistor select (held low)
//   resPtatEnable_n PTAT resistor enable, active-low
//   c1, c2          cap cell switch controls {CB,CA}
//   cmp_swap        comparator input swap
//   busy            conversion in progress
//   done            one-cycle completion pulse
//   code            final trim code, held until the next done
// -----------------------------------------------------------------------------
module bg_sar_ctrl #(
    parameter int NBITS         = 8,
    parameter int SETTLE_CYCLES = 16,
    parameter int PWRUP_CYCLES  = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       coarse_in,
    input  logic [7:0]       diode_n_sel,
    input  logic             cmpo,
    output logic             pwrup,
    output logic [NBITS-1:0] idacFine,
    output logic [7:0]       idacCoarse,
    output logic [3:0]       idacOutSelect_n,
    output logic [7:0]       diodeSelect,
    output logic             resStableSelect,
    output logic             resPtatEnable_n,
    output logic [1:0]       c1,
    output logic [1:0]       c2,
    output logic             cmp_swap,
    output logic             busy,
    output logic             done,
    output logic [NBITS-1:0] code
);

    localparam int CNT_MAX = (PWRUP_CYCLES > SETTLE_CYCLES) ? PWRUP_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam int IDX_W   = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CNT_W-1:0] PWRUP_LOAD  = CNT_W'(PWRUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] MSB_IDX     = IDX_W'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_CODE    = NBITS'(1) << (NBITS - 1);

    typedef enum logic [3:0] {
        IDLE,
        PWRUP,
        CHARGE_A,
        GAP_A,
        CHARGE_B,
        GAP_B,
        SHARE,
        DECIDE,
        FINISH
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] bit_q;
    logic             cmpo_meta_q;
    logic             cmpo_sync_q;
    logic [7:0]       diode_n_q;

    logic             pwrup_q;
    logic [NBITS-1:0] fine_q;
    logic [7:0]       coarse_q;
    logic [3:0]       outsel_n_q;
    logic [7:0]       diode_q;
    logic             ptat_en_n_q;
    logic [1:0]       c1_q;
    logic [1:0]       c2_q;
    logic             busy_q;
    logic             done_q;
    logic [NBITS-1:0] code_q;

`ifdef BG_SAR_CTRL_CHOP_EN
    logic             pass_q;     // 0: normal pass, 1: swapped pass
    logic             keep1_q;    // pass-1 verdict for the current bit
    logic             swap_q;
`endif

    logic [NBITS-1:0] bit_mask_d;
    logic [NBITS-1:0] next_mask_d;
    logic             keep_bit_d;
    logic [NBITS-1:0] fine_dec_d;
    logic [NBITS-1:0] fine_next_d;

    // Resolve the current trial bit and prepare the next trial code.
    always_comb begin
        bit_mask_d  = NBITS'(1) << bit_q;
        next_mask_d = bit_mask_d >> 1;
`ifdef BG_SAR_CTRL_CHOP_EN
        // In the swapped pass the comparator polarity is reversed, so an
        // inverted result of 1 means "keep". Either pass voting keep wins.
        keep_bit_d  = keep1_q | ~cmpo_sync_q;
`else
        keep_bit_d  = cmpo_sync_q;
`endif
        fine_dec_d  = keep_bit_d ? fine_q : (fine_q & ~bit_mask_d);
        fine_next_d = fine_dec_d | next_mask_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            cmpo_meta_q <= 1'b0;
            cmpo_sync_q <= 1'b0;
            diode_n_q   <= '0;
            pwrup_q     <= 1'b0;
            fine_q      <= '0;
            coarse_q    <= '0;
            outsel_n_q  <= 4'hF;
            diode_q     <= '0;
            ptat_en_n_q <= 1'b1;
            c1_q        <= '0;
            c2_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            code_q      <= '0;
`ifdef BG_SAR_CTRL_CHOP_EN
            pass_q      <= 1'b0;
            keep1_q     <= 1'b0;
            swap_q      <= 1'b0;
`endif
        end else begin
            cmpo_meta_q <= cmpo;
            cmpo_sync_q <= cmpo_meta_q;
            done_q      <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (start) begin
                        coarse_q    <= coarse_in;
                        diode_n_q   <= diode_n_sel;
                        busy_q      <= 1'b1;
                        pwrup_q     <= 1'b1;
                        ptat_en_n_q <= 1'b0;
                        outsel_n_q  <= 4'b1110;   // IDAC output 0 drives VD
                        cnt_q       <= PWRUP_LOAD;
                        state_q     <= PWRUP;
                    end
                end

                PWRUP: begin
                    if (cnt_q == '0) begin
                        fine_q  <= MSB_CODE;
                        bit_q   <= MSB_IDX;
                        diode_q <= 8'h01;
                        c1_q    <= 2'b01;
                        c2_q    <= 2'b00;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= CHARGE_A;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                CHARGE_A: begin
                    if (cnt_q == '0) begin
                        c1_q    <= 2'b00;
                        c2_q    <= 2'b00;
                        state_q <= GAP_A;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                GAP_A: begin
                    diode_q <= diode_n_q;
                    c1_q    <= 2'b00;
                    c2_q    <= 2'b01;
                    cnt_q   <= SETTLE_LOAD;
                    state_q <= CHARGE_B;
                end

                CHARGE_B: begin
                    if (cnt_q == '0) begin
                        c1_q    <= 2'b00;
                        c2_q    <= 2'b00;
                        state_q <= GAP_B;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                GAP_B: begin
                    diode_q <= 8'h00;
                    c1_q    <= 2'b10;
                    c2_q    <= 2'b10;
                    cnt_q   <= SETTLE_LOAD;
                    state_q <= SHARE;
                end

                SHARE: begin
                    if (cnt_q == '0) begin
                        c1_q    <= 2'b00;
                        c2_q    <= 2'b00;
                        state_q <= DECIDE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end

                DECIDE: begin
`ifdef BG_SAR_CTRL_CHOP_EN
                    if (!pass_q) begin
                        // First pass done: rerun the same trial swapped.
                        keep1_q <= cmpo_sync_q;
                        pass_q  <= 1'b1;
                        swap_q  <= 1'b1;
                        diode_q <= 8'h01;
                        c1_q    <= 2'b01;
                        c2_q    <= 2'b00;
                        cnt_q   <= SETTLE_LOAD;
                        state_q <= CHARGE_A;
                    end else begin
                        pass_q <= 1'b0;
                        swap_q <= 1'b0;
`endif
                        if (bit_q != '0) begin
                            fine_q  <= fine_next_d;
                            bit_q   <= bit_q - IDX_W'(1);
                            diode_q <= 8'h01;
                            c1_q    <= 2'b01;
                            c2_q    <= 2'b00;
                            cnt_q   <= SETTLE_LOAD;
                            state_q <= CHARGE_A;
                        end else begin
                            // Last bit: publish the resolved code together
                            // with done so the two are seen in the same cycle.
                            fine_q  <= fine_dec_d;
                            code_q  <= fine_dec_d;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= FINISH;
                        end
`ifdef BG_SAR_CTRL_CHOP_EN
                    end
`endif
                end

                FINISH: begin
                    // Bias (pwrup, IDAC outputs) stays on; caps already idle.
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pwrup           = pwrup_q;
    assign idacFine        = fine_q;
    assign idacCoarse      = coarse_q;
    assign idacOutSelect_n = outsel_n_q;
    assign diodeSelect     = diode_q;
    assign resStableSelect = 1'b0;
    assign resPtatEnable_n = ptat_en_n_q;
    assign c1              = c1_q;
    assign c2              = c2_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign code            = code_q;
`ifdef BG_SAR_CTRL_CHOP_EN
    assign cmp_swap        = swap_q;
`else
    assign cmp_swap        = 1'b0;
`endif

endmodule

// File: tb/tb_bg_sar_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bg_sar_ctrl
//
// Self-checking bench for bg_sar_ctrl. A comparator model closes the loop on
// idacFine; expected codes and trial sequences come from a plain binary-search
// reference. Build with +define+BG_SAR_CTRL_CHOP_EN to cover the chopped mode.
// -----------------------------------------------------------------------------
module tb_bg_sar_ctrl;

    localparam int NB = 8;
    localparam int SC = 4;
    localparam int PC = 8;
`ifdef BG_SAR_CTRL_CHOP_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif
    localparam int BITC = 3 * SC + 3;
    localparam int LAT  = PC + NB * BITC * PASSES;
    localparam int NROW = 7;

    logic          clk;
    logic          reset;
    logic          start;
    logic [7:0]    coarse_in;
    logic [7:0]    diode_n_sel;
    logic          cmpo;
    logic          pwrup;
    logic [NB-1:0] idacFine;
    logic [7:0]    idacCoarse;
    logic [3:0]    idacOutSelect_n;
    logic [7:0]    diodeSelect;
    logic          resStableSelect;
    logic          resPtatEnable_n;
    logic [1:0]    c1;
    logic [1:0]    c2;
    logic          cmp_swap;
    logic          busy;
    logic          done;
    logic [NB-1:0] code;

    int n_checks = 0;
    int n_fail   = 0;

    // Comparator environment: mode 0 = tied low, 1 = tied high,
    // 2 = balances at threshold (ideal output is 1 while trial <= thr).
    // A swapped comparator presents the inverted result.
    int         cmp_mode = 0;
    logic [7:0] cmp_thr  = 8'h00;
    logic       cmp_raw;

    always_comb begin
        cmp_raw = 1'b0;
        case (cmp_mode)
            1:       cmp_raw = 1'b1;
            2:       cmp_raw = (idacFine <= cmp_thr);
            default: cmp_raw = 1'b0;
        endcase
        cmpo = cmp_raw ^ cmp_swap;
    end

    bg_sar_ctrl #(
        .NBITS        (NB),
        .SETTLE_CYCLES(SC),
        .PWRUP_CYCLES (PC)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .coarse_in      (coarse_in),
        .diode_n_sel    (diode_n_sel),
        .cmpo           (cmpo),
        .pwrup          (pwrup),
        .idacFine       (idacFine),
        .idacCoarse     (idacCoarse),
        .idacOutSelect_n(idacOutSelect_n),
        .diodeSelect    (diodeSelect),
        .resStableSelect(resStableSelect),
        .resPtatEnable_n(resPtatEnable_n),
        .c1             (c1),
        .c2             (c2),
        .cmp_swap       (cmp_swap),
        .busy           (busy),
        .done           (done),
        .code           (code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference SAR: try each bit MSB first, keep it when the ideal comparator
    // says the trial does not exceed the balance point.
    function automatic void ref_sar(input int m, input logic [7:0] t,
                                    output logic [7:0] c, output logic [63:0] seq);
        logic [7:0] trial;
        c   = 8'h00;
        seq = '0;
        for (int b = NB - 1; b >= 0; b--) begin
            trial = c | (8'h01 << b);
            seq   = {seq[55:0], trial};
            if (m == 1 || (m == 2 && trial <= t)) c = trial;
        end
    endfunction

    // Observations collected by run_conv.
    int          obs_done_at, obs_done_cnt, obs_busy_low, obs_busy_after;
    int          obs_phase_bad, obs_diode_bad, obs_coarse_bad, obs_fine_bad;
    int          obs_ntrial, obs_swap_cnt;
    logic [7:0]  obs_code;
    logic [63:0] obs_seq;
    logic [6:0]  obs_bias;   // {busy, pwrup, outsel_n[3:0], ptat_en_n} right after start

    // Drives one conversion and records what the DUT did, cycle by cycle.
    task automatic run_conv(input logic [7:0] cv, input logic [7:0] dv,
                            input int stray_at, input bit fin_start);
        logic [1:0]    pc1, pc2;
        logic [NB-1:0] pfine;
        obs_done_at = -1; obs_done_cnt = 0; obs_busy_low = -1; obs_busy_after = 0;
        obs_phase_bad = 0; obs_diode_bad = 0; obs_coarse_bad = 0; obs_fine_bad = 0;
        obs_ntrial = 0; obs_swap_cnt = 0; obs_code = '0; obs_seq = '0; obs_bias = '0;
        pc1 = '0; pc2 = '0; pfine = idacFine;
        @(negedge clk);
        start = 1'b1; coarse_in = cv; diode_n_sel = dv;
        @(negedge clk);
        for (int j = 0; j <= LAT + 2; j++) begin
            if (j == 0) begin
                start     = 1'b0;
                coarse_in = ~cv;
                diode_n_sel = ~dv;
                obs_bias  = {busy, pwrup, idacOutSelect_n, resPtatEnable_n};
            end
            if (j == stray_at) begin
                start = 1'b1; coarse_in = 8'hC3; diode_n_sel = 8'h5C;
            end
            if (j == stray_at + 1) start = 1'b0;
            if (fin_start && j == LAT) start = 1'b1;
            if (fin_start && j == LAT + 1) start = 1'b0;

            if (done) begin
                obs_done_cnt++;
                if (obs_done_at < 0) begin
                    obs_done_at = j;
                    obs_code    = code;
                end
            end
            if (!busy && obs_busy_low < 0) obs_busy_low = j;
            if (busy && j > LAT) obs_busy_after++;
            if (busy && idacCoarse !== cv) obs_coarse_bad++;
            if (c1 != 2'b00 && c2 != 2'b00 && !(c1 == 2'b10 && c2 == 2'b10)) obs_phase_bad++;
            if ((pc1 == 2'b01 && c2 != 2'b00) || (pc2 == 2'b01 && c1 != 2'b00)) obs_phase_bad++;
            if (c1 == 2'b01 && diodeSelect !== 8'h01) obs_diode_bad++;
            if (c2 == 2'b01 && diodeSelect !== dv) obs_diode_bad++;
            if (c1 == 2'b10 && diodeSelect !== 8'h00) obs_diode_bad++;
            if (c1 == 2'b01 && pc1 != 2'b01) begin
                if (cmp_swap) obs_swap_cnt++;
                else begin
                    obs_seq = {obs_seq[55:0], idacFine};
                    obs_ntrial++;
                end
            end
            if (j > 0 && idacFine !== pfine && !(c1 == 2'b01 && pc1 != 2'b01) && !done)
                obs_fine_bad++;
            pc1 = c1; pc2 = c2; pfine = idacFine;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pwrup !== 1'b0) begin n_fail++; $display("FAIL reset_pwrup: got %b want 0", pwrup); end
        n_checks++; if (idacFine !== '0) begin n_fail++; $display("FAIL reset_fine: got %h want 00", idacFine); end
        n_checks++; if (idacCoarse !== 8'h00) begin n_fail++; $display("FAIL reset_coarse: got %h want 00", idacCoarse); end
        n_checks++; if (idacOutSelect_n !== 4'hF) begin n_fail++; $display("FAIL reset_outsel: got %h want F", idacOutSelect_n); end
        n_checks++; if (diodeSelect !== 8'h00) begin n_fail++; $display("FAIL reset_diode: got %h want 00", diodeSelect); end
        n_checks++; if (resStableSelect !== 1'b0) begin n_fail++; $display("FAIL reset_resstable: got %b want 0", resStableSelect); end
        n_checks++; if (resPtatEnable_n !== 1'b1) begin n_fail++; $display("FAIL reset_ptat: got %b want 1", resPtatEnable_n); end
        n_checks++; if ({c1, c2} !== 4'h0) begin n_fail++; $display("FAIL reset_caps: got %b want 0000", {c1, c2}); end
        n_checks++; if (cmp_swap !== 1'b0) begin n_fail++; $display("FAIL reset_swap: got %b want 0", cmp_swap); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
        n_checks++; if (code !== '0) begin n_fail++; $display("FAIL reset_code: got %h want 00", code); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int         row_mode [NROW];
    logic [7:0] row_thr  [NROW];
    logic [7:0] row_cv   [NROW];
    logic [7:0] row_dv   [NROW];
    int         row_stray[NROW];
    bit         row_fin  [NROW];

    task automatic test_conversions(input int first, input int last);
        logic [7:0]  exp_code;
        logic [63:0] exp_seq;
        for (int r = first; r <= last; r++) begin
            cmp_mode = row_mode[r];
            cmp_thr  = row_thr[r];
            ref_sar(row_mode[r], row_thr[r], exp_code, exp_seq);
            run_conv(row_cv[r], row_dv[r], row_stray[r], row_fin[r]);
            n_checks++; if (obs_bias !== 7'b11_1110_0) begin n_fail++; $display("FAIL row%0d start_outputs: got %b want 1111100", r, obs_bias); end
            n_checks++; if (obs_done_at != LAT) begin n_fail++; $display("FAIL row%0d done_latency: got %0d want %0d", r, obs_done_at, LAT); end
            n_checks++; if (obs_done_cnt != 1) begin n_fail++; $display("FAIL row%0d done_pulses: got %0d want 1", r, obs_done_cnt); end
            n_checks++; if (obs_busy_low != LAT) begin n_fail++; $display("FAIL row%0d busy_fall: got %0d want %0d", r, obs_busy_low, LAT); end
            n_checks++; if (obs_busy_after != 0) begin n_fail++; $display("FAIL row%0d busy_after_done: got %0d want 0", r, obs_busy_after); end
            n_checks++; if (obs_code !== exp_code) begin n_fail++; $display("FAIL row%0d code: got %h want %h", r, obs_code, exp_code); end
            n_checks++; if (code !== exp_code) begin n_fail++; $display("FAIL row%0d code_held: got %h want %h", r, code, exp_code); end
            n_checks++; if (obs_ntrial != NB || obs_seq !== exp_seq) begin n_fail++; $display("FAIL row%0d trials: got %h (%0d) want %h", r, obs_seq, obs_ntrial, exp_seq); end
            n_checks++; if (obs_swap_cnt != (PASSES - 1) * NB) begin n_fail++; $display("FAIL row%0d swapped_passes: got %0d want %0d", r, obs_swap_cnt, (PASSES - 1) * NB); end
            n_checks++; if (obs_phase_bad != 0) begin n_fail++; $display("FAIL row%0d cap_phases: got %0d bad cycles want 0", r, obs_phase_bad); end
            n_checks++; if (obs_diode_bad != 0) begin n_fail++; $display("FAIL row%0d diode_select: got %0d bad cycles want 0", r, obs_diode_bad); end
            n_checks++; if (obs_coarse_bad != 0) begin n_fail++; $display("FAIL row%0d coarse_held: got %0d bad cycles want 0", r, obs_coarse_bad); end
            n_checks++; if (obs_fine_bad != 0) begin n_fail++; $display("FAIL row%0d fine_stable: got %0d bad changes want 0", r, obs_fine_bad); end
            n_checks++; if (pwrup !== 1'b1 || idacOutSelect_n !== 4'b1110) begin n_fail++; $display("FAIL row%0d bias_kept: got %b %b want 1 1110", r, pwrup, idacOutSelect_n); end
        end
    endtask

    // Reset during bit 4 of a threshold search: everything returns to reset
    // values on the next edge and no done appears afterwards.
    task automatic test_reset_mid();
        int dones;
        cmp_mode = 2; cmp_thr = 8'h5A;
        @(negedge clk);
        start = 1'b1; coarse_in = 8'h77; diode_n_sel = 8'h0F;
        @(negedge clk);
        start = 1'b0;
        repeat (PC + 3 * BITC * PASSES + 5) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect, resStableSelect,
             resPtatEnable_n, c1, c2, cmp_swap, busy, done, code} !==
            {1'b0, 8'h00, 8'h00, 4'hF, 8'h00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got pwrup=%b fine=%h coarse=%h sel=%h diode=%h ptat=%b c1=%b c2=%b swap=%b busy=%b done=%b code=%h want reset values",
                     pwrup, idacFine, idacCoarse, idacOutSelect_n, diodeSelect, resPtatEnable_n, c1, c2, cmp_swap, busy, done, code);
        end
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        for (int j = 0; j < 3 * BITC; j++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", dones); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; coarse_in = 8'h00; diode_n_sel = 8'h00;

        row_mode[0] = 1; row_thr[0] = 8'h00; row_cv[0] = 8'hA5; row_dv[0] = 8'h3C; row_stray[0] = -5; row_fin[0] = 1'b0;
        row_mode[1] = 0; row_thr[1] = 8'h00; row_cv[1] = 8'h12; row_dv[1] = 8'h80; row_stray[1] = 30; row_fin[1] = 1'b1;
        row_mode[2] = 2; row_thr[2] = 8'h5A; row_cv[2] = 8'h33; row_dv[2] = 8'h0F; row_stray[2] = 50; row_fin[2] = 1'b1;
        for (int r = 3; r < NROW; r++) begin
            row_mode[r]  = 2;
            row_thr[r]   = 8'($urandom_range(0, 255));
            row_cv[r]    = 8'($urandom);
            row_dv[r]    = 8'($urandom_range(2, 255));
            row_stray[r] = int'($urandom_range(1, LAT - 2));
            row_fin[r]   = 1'($urandom);
        end
        row_thr[NROW - 1] = 8'hFF;   // top-of-range balance point

        test_reset();
        test_conversions(0, 1);
        test_reset_mid();
        test_conversions(2, NROW - 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
